// File: rtl/spi_oversampled_mem_interface.sv
// rtl/spi_oversampled_mem_interface.sv - oversampled SPI slave driving register-map strobes
//
// Purpose:
//   SPI mode-0 slave, MSB first, built entirely in the clk_i domain. sck/sdi/cs_n
//   are synchronized and edge-detected, and a frame of
//   {INST_WIDTH instruction, ADDR_WIDTH address, DATA_WIDTH data} is decoded into
//   one-cycle write/read strobes for a register map.
//   Requires f(clk_i) >= 8 x f(sck).
//
// Optional feature macro: SPI_BURST_EN
//   Defined   : data bytes keep streaming after the first one, addr_o auto-increments.
//   Undefined : single-byte frames; extra sck edges are ignored until cs_n rises.
//
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   sck_i, sdi_i   asynchronous SPI clock and data in
//   cs_ni          asynchronous chip select, active low
//   sdo_o          SPI data out (MSB of tx shift register)
//   sdo_oe_o       high while a read data phase is active
//   addr_o         register address
//   write_data_o   register write data
//   write_en_o     one-cycle write strobe
//   read_data_i    register read data, valid the cycle after read_en_o
//   read_en_o      one-cycle read strobe
//   abort_o        one-cycle pulse when cs_n rises mid-frame
module spi_oversampled_mem_interface #(
   parameter int INST_WIDTH  = 1,
   parameter int ADDR_WIDTH  = 7,
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  sck_i,
   input  logic                  sdi_i,
   input  logic                  cs_ni,
   output logic                  sdo_o,
   output logic                  sdo_oe_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] write_data_o,
   output logic                  write_en_o,
   input  logic [DATA_WIDTH-1:0] read_data_i,
   output logic                  read_en_o,
   output logic                  abort_o
);

   localparam int SH_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int MAXW  = (SH_W > INST_WIDTH) ? SH_W : INST_WIDTH;
   localparam int CNT_W = $clog2(MAXW) + 1;

   localparam logic [CNT_W-1:0] INST_LAST = CNT_W'(INST_WIDTH - 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, INST, ADDR, RD_FETCH, DATA, WAIT_CS} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sck_sync_q, sdi_sync_q, cs_sync_q;
   logic                    sck_dly_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SH_W-1:0]         rx_q, rx_d;
   logic [DATA_WIDTH-1:0]   tx_q, tx_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    is_read_q, is_read_d;
   logic                    oe_q, oe_d;
   logic                    we_q, we_d;
   logic                    re_q, re_d;
   logic                    abort_q, abort_d;
   logic                    frame_bit_q, frame_bit_d;  // a bit of an unfinished field was received
   logic                    data_rise_q, data_rise_d;  // a data-phase rise happened in this byte
   logic                    fetch_q;                   // read_data_i is valid this cycle

   logic            sck_s, sdi_s, cs_s;
   logic            rise, fall;
   logic [SH_W-1:0] rx_next;

   assign sck_s   = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s   = sdi_sync_q[SYNC_STAGES-1];
   assign cs_s    = cs_sync_q[SYNC_STAGES-1];
   assign rise    = sck_s & ~sck_dly_q;
   assign fall    = ~sck_s & sck_dly_q;
   assign rx_next = {rx_q[SH_W-2:0], sdi_s};

   assign sdo_o        = tx_q[DATA_WIDTH-1];
   assign sdo_oe_o     = oe_q;
   assign addr_o       = addr_q;
   assign write_data_o = wdata_q;
   assign write_en_o   = we_q;
   assign read_en_o    = re_q;
   assign abort_o      = abort_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      is_read_d   = is_read_q;
      oe_d        = oe_q;
      frame_bit_d = frame_bit_q;
      data_rise_d = data_rise_q;
      we_d        = 1'b0;
      re_d        = 1'b0;
      abort_d     = 1'b0;

      if (cs_s) begin
         // cs_n high wins over any sck activity in the same cycle
         state_d     = IDLE;
         cnt_d       = '0;
         rx_d        = '0;
         tx_d        = '0;
         oe_d        = 1'b0;
         frame_bit_d = 1'b0;
         data_rise_d = 1'b0;
         if (frame_bit_q && (state_q == INST || state_q == ADDR ||
                             state_q == RD_FETCH || state_q == DATA)) begin
            abort_d = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = INST;
               cnt_d       = '0;
               frame_bit_d = 1'b0;
               data_rise_d = 1'b0;
            end
            INST: begin
               if (rise) begin
                  frame_bit_d = 1'b1;
                  is_read_d   = sdi_s;  // last instruction bit is the field LSB
                  if (cnt_q == INST_LAST) begin
                     cnt_d   = '0;
                     state_d = ADDR;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ADDR: begin
               if (rise) begin
                  rx_d = rx_next;
                  if (cnt_q == ADDR_LAST) begin
                     cnt_d  = '0;
                     addr_d = rx_next[ADDR_WIDTH-1:0];
                     if (is_read_q) begin
                        re_d    = 1'b1;
                        state_d = RD_FETCH;
                     end else begin
                        state_d = DATA;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            RD_FETCH: begin
               // first cycle here is the read_en_o cycle; data arrives one later
               if (fetch_q) begin
                  tx_d    = read_data_i;
                  oe_d    = 1'b1;
                  state_d = DATA;
               end
            end
            DATA: begin
               if (is_read_q && fetch_q) begin
                  tx_d = read_data_i;  // burst prefetch reload
               end
               if (rise) begin
                  frame_bit_d = 1'b1;
                  if (is_read_q) begin
                     data_rise_d = 1'b1;
                  end else begin
                     rx_d = rx_next;
                  end
                  if (cnt_q == DATA_LAST) begin
                     cnt_d = '0;
                     if (!is_read_q) begin
                        wdata_d = rx_next[DATA_WIDTH-1:0];
                        we_d    = 1'b1;
                     end
`ifdef SPI_BURST_EN
                     frame_bit_d = 1'b0;
                     data_rise_d = 1'b0;
                     if (is_read_q) begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        re_d   = 1'b1;
                     end
`else
                     state_d = WAIT_CS;
`endif
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else if (fall && is_read_q && data_rise_q) begin
                  tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
            WAIT_CS: begin
               state_d = WAIT_CS;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

`ifdef SPI_BURST_EN
      // write burst advances the address the cycle after the strobe
      if (we_q) begin
         addr_d = addr_q + ADDR_WIDTH'(1);
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_sync_q  <= '0;
         sdi_sync_q  <= '0;
         cs_sync_q   <= '1;
         sck_dly_q   <= 1'b0;
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         is_read_q   <= 1'b0;
         oe_q        <= 1'b0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         abort_q     <= 1'b0;
         frame_bit_q <= 1'b0;
         data_rise_q <= 1'b0;
         fetch_q     <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_ni};
         sck_dly_q   <= sck_s;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         is_read_q   <= is_read_d;
         oe_q        <= oe_d;
         we_q        <= we_d;
         re_q        <= re_d;
         abort_q     <= abort_d;
         frame_bit_q <= frame_bit_d;
         data_rise_q <= data_rise_d;
         fetch_q     <= re_q;
      end
   end

endmodule
